// File: rtl/csr_trap_seq.sv
// rtl/csr_trap_seq.sv - machine-mode trap entry / mret CSR sequencer with core CSR port arbitration
module csr_trap_seq #(
   parameter int CAUSE_W   = 4,
   parameter int EPC_ALIGN = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               trap_valid_i,
   input  logic [CAUSE_W-1:0] trap_cause_i,
   input  logic [31:0]        trap_pc_i,
   input  logic               mret_valid_i,
   input  logic               core_en_i,
   input  logic [1:0]         core_op_i,
   input  logic [11:0]        core_addr_i,
   input  logic [31:0]        core_wdata_i,
   output logic [31:0]        core_rdata_o,
   output logic               core_stall_o,
   output logic               csr_en_o,
   output logic [1:0]         csr_op_o,
   output logic [11:0]        csr_addr_o,
   output logic [31:0]        csr_wdata_o,
   input  logic [31:0]        csr_rdata_i,
   output logic               busy_o,
   output logic               redirect_valid_o,
   output logic [31:0]        redirect_pc_o
);

   typedef enum logic [3:0] {
      IDLE, T_EPC, T_CAUSE, T_MIE, T_MPIE, T_VEC,
      M_RD, M_MIE, M_MPIE, M_EPC, DONE
   } state_t;

   localparam logic [1:0]  OP_RW      = 2'b01;
   localparam logic [1:0]  OP_RS      = 2'b10;
   localparam logic [1:0]  OP_RC      = 2'b11;
   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [31:0] MIE_BIT    = 32'h0000_0008;
   localparam logic [31:0] MPIE_BIT   = 32'h0000_0080;

   state_t             state_q, state_d;
   logic [CAUSE_W-1:0] cause_q;
   logic [31:0]        pc_q;
   logic               mie_q;
   logic               mpie_q;
   logic [31:0]        redirect_pc_q;
   logic [31:0]        epc_wdata;

   assign epc_wdata        = (EPC_ALIGN != 0) ? {pc_q[31:1], 1'b0} : pc_q;
   assign busy_o           = (state_q != IDLE);
   assign redirect_valid_o = (state_q == DONE);
   assign redirect_pc_o    = redirect_pc_q;

   always_comb begin
      state_d      = state_q;
      csr_en_o     = 1'b0;
      csr_op_o     = 2'b00;
      csr_addr_o   = 12'h000;
      csr_wdata_o  = 32'h0;
      core_rdata_o = 32'h0;
      core_stall_o = core_en_i;
      case (state_q)
         IDLE: begin
            if (trap_valid_i) begin
               state_d = T_EPC;
            end else if (mret_valid_i) begin
               state_d = M_RD;
            end else begin
               // The port is free: hand the pipeline request straight through.
               core_stall_o = 1'b0;
               if (core_en_i) begin
                  csr_en_o     = 1'b1;
                  csr_op_o     = core_op_i;
                  csr_addr_o   = core_addr_i;
                  csr_wdata_o  = core_wdata_i;
                  core_rdata_o = csr_rdata_i;
               end
            end
         end
         T_EPC: begin
            csr_en_o = 1'b1; csr_op_o = OP_RW; csr_addr_o = A_MEPC;
            csr_wdata_o = epc_wdata;
            state_d = T_CAUSE;
         end
         T_CAUSE: begin
            csr_en_o = 1'b1; csr_op_o = OP_RW; csr_addr_o = A_MCAUSE;
            csr_wdata_o = {{(32-CAUSE_W){1'b0}}, cause_q};
            state_d = T_MIE;
         end
         T_MIE: begin
            csr_en_o = 1'b1; csr_op_o = OP_RC; csr_addr_o = A_MSTATUS;
            csr_wdata_o = MIE_BIT;
            state_d = T_MPIE;
         end
         T_MPIE: begin
            csr_en_o = 1'b1; csr_op_o = mie_q ? OP_RS : OP_RC; csr_addr_o = A_MSTATUS;
            csr_wdata_o = MPIE_BIT;
            state_d = T_VEC;
         end
         T_VEC: begin
            csr_en_o = 1'b1; csr_op_o = OP_RS; csr_addr_o = A_MTVEC;
            state_d = DONE;
         end
         M_RD: begin
            csr_en_o = 1'b1; csr_op_o = OP_RS; csr_addr_o = A_MSTATUS;
            state_d = M_MIE;
         end
         M_MIE: begin
            csr_en_o = 1'b1; csr_op_o = mpie_q ? OP_RS : OP_RC; csr_addr_o = A_MSTATUS;
            csr_wdata_o = MIE_BIT;
            state_d = M_MPIE;
         end
         M_MPIE: begin
            csr_en_o = 1'b1; csr_op_o = OP_RS; csr_addr_o = A_MSTATUS;
            csr_wdata_o = MPIE_BIT;
            state_d = M_EPC;
         end
         M_EPC: begin
            csr_en_o = 1'b1; csr_op_o = OP_RS; csr_addr_o = A_MEPC;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         cause_q       <= '0;
         pc_q          <= 32'h0;
         mie_q         <= 1'b0;
         mpie_q        <= 1'b0;
         redirect_pc_q <= 32'h0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (trap_valid_i) begin
                  cause_q <= trap_cause_i;
                  pc_q    <= trap_pc_i;
               end
            end
            T_MIE:   mie_q         <= csr_rdata_i[3];
            T_VEC:   redirect_pc_q <= {csr_rdata_i[31:2], 2'b00};
            M_RD:    mpie_q        <= csr_rdata_i[7];
            M_EPC:   redirect_pc_q <= csr_rdata_i;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_trap_seq.sv
// tb/tb_csr_trap_seq.sv - self-checking bench for csr_trap_seq against a behavioural CSR file and trap/mret model
module tb_csr_trap_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trap_valid = 1'b0;
   logic [3:0]  trap_cause = 4'h0;
   logic [31:0] trap_pc = 32'h0;
   logic        mret_valid = 1'b0;
   logic        core_en = 1'b0;
   logic [1:0]  core_op = 2'b00;
   logic [11:0] core_addr = 12'h0;
   logic [31:0] core_wdata = 32'h0;
   logic [31:0] core_rdata;
   logic        core_stall;
   logic        csr_en;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        busy;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   logic        poke_en = 1'b0;
   logic [11:0] poke_addr = 12'h0;
   logic [31:0] poke_data = 32'h0;
   logic [31:0] csr_mem [0:4095];
   int          acc_300 = 0;
   int          acc_305 = 0;
   int          pulses = 0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   csr_trap_seq #(.CAUSE_W(4), .EPC_ALIGN(1)) dut (
      .clk_i(clk), .rst_i(rst),
      .trap_valid_i(trap_valid), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc),
      .mret_valid_i(mret_valid),
      .core_en_i(core_en), .core_op_i(core_op), .core_addr_i(core_addr),
      .core_wdata_i(core_wdata), .core_rdata_o(core_rdata), .core_stall_o(core_stall),
      .csr_en_o(csr_en), .csr_op_o(csr_op), .csr_addr_o(csr_addr),
      .csr_wdata_o(csr_wdata), .csr_rdata_i(csr_rdata),
      .busy_o(busy), .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc)
   );

   // Behavioural CSR file: combinational read of the old value, RW/RS/RC update on the edge.
   assign csr_rdata = csr_mem[csr_addr];

   always @(posedge clk) begin
      if (redirect_valid) pulses <= pulses + 1;
      if (poke_en) begin
         csr_mem[poke_addr] <= poke_data;
      end else if (csr_en) begin
         case (csr_op)
            2'b01:   csr_mem[csr_addr] <= csr_wdata;
            2'b10:   csr_mem[csr_addr] <= csr_mem[csr_addr] | csr_wdata;
            2'b11:   csr_mem[csr_addr] <= csr_mem[csr_addr] & ~csr_wdata;
            default: ;
         endcase
         if (csr_addr == 12'h300) acc_300 <= acc_300 + 1;
         if (csr_addr == 12'h305) acc_305 <= acc_305 + 1;
      end
   end

   typedef struct {
      bit          is_mret;
      logic [31:0] pc;
      logic [3:0]  cause;
      logic [31:0] mtvec;
      logic [31:0] mstatus;
      logic [31:0] mepc;
      logic [31:0] exp_mepc;
      logic [31:0] exp_mcause;
      logic [31:0] exp_mstatus;
      logic [31:0] exp_redirect;
      int          exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit m, logic [31:0] pc, logic [3:0] c, logic [31:0] tv,
                               logic [31:0] ms, logic [31:0] ep, logic [31:0] e_ep,
                               logic [31:0] e_mc, logic [31:0] e_ms, logic [31:0] e_rd, int lat);
      vec_t v;
      v.is_mret = m; v.pc = pc; v.cause = c; v.mtvec = tv; v.mstatus = ms; v.mepc = ep;
      v.exp_mepc = e_ep; v.exp_mcause = e_mc; v.exp_mstatus = e_ms;
      v.exp_redirect = e_rd; v.exp_lat = lat;
      return v;
   endfunction

   // Architectural effect of a trap or mret on the machine CSRs.
   function automatic vec_t model(vec_t v);
      vec_t r = v;
      logic [31:0] ms = v.mstatus;
      logic        old;
      r.exp_mcause = 32'h0;
      r.exp_mepc   = v.mepc;
      if (!v.is_mret) begin
         r.exp_mepc     = v.pc & 32'hFFFF_FFFE;
         r.exp_mcause   = 32'(v.cause);
         old            = ms[3];
         ms[3]          = 1'b0;
         ms[7]          = old;
         r.exp_redirect = v.mtvec & 32'hFFFF_FFFC;
         r.exp_lat      = 6;
      end else begin
         ms[3]          = ms[7];
         ms[7]          = 1'b1;
         r.exp_redirect = v.mepc;
         r.exp_lat      = 5;
      end
      r.exp_mstatus = ms;
      return r;
   endfunction

   task automatic poke(input logic [11:0] a, input logic [31:0] d);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   // Caller has already driven the request; returns cycles until the redirect pulse (-1 on timeout).
   task automatic wait_redirect(output int lat, output logic [31:0] rpc);
      lat = -1;
      rpc = 32'h0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         trap_valid = 1'b0;
         mret_valid = 1'b0;
         core_en    = 1'b0;
         if (k == 1) check("busy_after_accept", 32'(busy), 32'h1);
         if (redirect_valid) begin
            lat = k;
            rpc = redirect_pc;
            break;
         end
      end
   endtask

   task automatic verify_result(input string tag, input vec_t v, input int lat, input logic [31:0] rpc);
      check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
      check({tag, "_redirect_pc"}, rpc, v.exp_redirect);
      @(negedge clk);
      check({tag, "_pulse_single"}, 32'(redirect_valid), 32'h0);
      check({tag, "_busy_clear"}, 32'(busy), 32'h0);
      check({tag, "_pc_held"}, redirect_pc, v.exp_redirect);
      check({tag, "_mepc"}, csr_mem[12'h341], v.exp_mepc);
      check({tag, "_mcause"}, csr_mem[12'h342], v.exp_mcause);
      check({tag, "_mstatus"}, csr_mem[12'h300], v.exp_mstatus);
   endtask

   task automatic apply_vec(input string tag, input vec_t v);
      int lat;
      logic [31:0] rpc;
      poke(12'h305, v.mtvec);
      poke(12'h300, v.mstatus);
      poke(12'h341, v.mepc);
      poke(12'h342, 32'h0);
      trap_valid = !v.is_mret;
      mret_valid = v.is_mret;
      trap_pc    = v.pc;
      trap_cause = v.cause;
      wait_redirect(lat, rpc);
      verify_result(tag, v, lat, rpc);
   endtask

   vec_t tbl [5];

   initial begin
      int          lat;
      logic [31:0] rpc;
      int          a300, a305, p0;
      vec_t        v;

      tbl[0] = mk(0, 32'h0000_1235, 4'd11, 32'h8000_0101, 32'h0000_0008, 32'h0,
                  32'h0000_1234, 32'd11, 32'h0000_0080, 32'h8000_0100, 6);
      tbl[1] = mk(1, 32'h0, 4'd0, 32'h0, 32'h0000_0000, 32'h0000_0200,
                  32'h0000_0200, 32'h0, 32'h0000_0080, 32'h0000_0200, 5);
      tbl[2] = mk(0, 32'hFFFF_FFFF, 4'd15, 32'h0000_0003, 32'h0000_0080, 32'h0,
                  32'hFFFF_FFFE, 32'd15, 32'h0000_0000, 32'h0000_0000, 6);
      tbl[3] = mk(1, 32'h0, 4'd0, 32'h0, 32'h0000_0080, 32'h1000_0004,
                  32'h1000_0004, 32'h0, 32'h0000_0088, 32'h1000_0004, 5);
      tbl[4] = mk(0, 32'h0040_0010, 4'd2, 32'h0000_4000, 32'h0000_1808, 32'h0,
                  32'h0040_0010, 32'd2, 32'h0000_1880, 32'h0000_4000, 6);

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_redirect_valid", 32'(redirect_valid), 32'h0);
      check("rst_redirect_pc", redirect_pc, 32'h0);
      check("rst_csr_en", 32'(csr_en), 32'h0);
      check("rst_stall", 32'(core_stall), 32'h0);

      for (int i = 0; i < 5; i++) apply_vec($sformatf("tbl%0d", i), tbl[i]);

      // Core access forwarded in IDLE
      poke(12'h340, 32'h1234_5678);
      core_en = 1'b1; core_op = 2'b01; core_addr = 12'h340; core_wdata = 32'hDEAD_BEEF;
      #1;
      check("fwd_en", 32'(csr_en), 32'h1);
      check("fwd_addr", 32'(csr_addr), 32'h340);
      check("fwd_op", 32'(csr_op), 32'h1);
      check("fwd_wdata", csr_wdata, 32'hDEAD_BEEF);
      check("fwd_rdata", core_rdata, 32'h1234_5678);
      check("fwd_stall", 32'(core_stall), 32'h0);
      @(negedge clk);
      core_en = 1'b0;
      check("fwd_written", csr_mem[12'h340], 32'hDEAD_BEEF);

      // Trap and mret together with a core request: trap wins, core stalled
      v = model(mk(0, 32'h0000_0AB1, 4'd5, 32'h0000_8004, 32'h0000_0008, 32'h0000_0300,
                   32'h0, 32'h0, 32'h0, 32'h0, 0));
      poke(12'h305, v.mtvec); poke(12'h300, v.mstatus); poke(12'h341, v.mepc); poke(12'h342, 32'h0);
      trap_valid = 1'b1; mret_valid = 1'b1; trap_pc = v.pc; trap_cause = v.cause;
      core_en = 1'b1; core_op = 2'b01; core_addr = 12'h340; core_wdata = 32'h5555_AAAA;
      #1;
      check("both_stall", 32'(core_stall), 32'h1);
      check("both_no_fwd", 32'(csr_en), 32'h0);
      check("both_rdata0", core_rdata, 32'h0);
      wait_redirect(lat, rpc);
      verify_result("both", v, lat, rpc);
      @(negedge clk);
      check("both_mret_dropped", 32'(busy), 32'h0);
      check("both_mscratch_kept", csr_mem[12'h340], 32'hDEAD_BEEF);

      // Reset in T_CAUSE aborts the sequence
      poke(12'h300, 32'h0000_0008); poke(12'h305, 32'h0000_7000); poke(12'h342, 32'h0);
      a300 = acc_300; a305 = acc_305; p0 = pulses;
      trap_valid = 1'b1; trap_pc = 32'h0000_0100; trap_cause = 4'd9;
      @(negedge clk);
      trap_valid = 1'b0;
      @(negedge clk);
      check("abort_in_cause", 32'(csr_addr), 32'h342);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_redirect_pc", redirect_pc, 32'h0);
      repeat (8) @(negedge clk);
      check("abort_no_mstatus", 32'(acc_300 - a300), 32'h0);
      check("abort_no_mtvec", 32'(acc_305 - a305), 32'h0);
      check("abort_no_pulse", 32'(pulses - p0), 32'h0);
      check("abort_mcause_kept", csr_mem[12'h342], 32'd9);

      // Trap held high: one sequence per IDLE sample, re-accept right after DONE
      poke(12'h300, 32'h0000_0008); poke(12'h305, 32'h0000_0100);
      p0 = pulses;
      trap_valid = 1'b1; trap_pc = 32'h0000_2000; trap_cause = 4'd3;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 2) begin
            core_en = 1'b1; core_op = 2'b10; core_addr = 12'h340; core_wdata = 32'h1;
         end
         if (k == 3) begin
            check("busy_core_stall", 32'(core_stall), 32'h1);
            check("busy_core_rdata", core_rdata, 32'h0);
            check("busy_owns_port", 32'(csr_addr), 32'h300);
            check("busy_t_mie_op", 32'(csr_op), 32'h3);
            core_en = 1'b0;
         end
         if (k == 6) check("hold_pulse1", 32'(redirect_valid), 32'h1);
         if (k == 7) check("hold_idle_gap", 32'(busy), 32'h0);
         if (k == 8) check("hold_reaccept", 32'(busy), 32'h1);
      end
      trap_valid = 1'b0;
      check("hold_two_pulses", 32'(pulses - p0), 32'h2);
      for (int k = 0; k < 10 && busy; k++) @(negedge clk);
      check("hold_drained", 32'(busy), 32'h0);

      // Randomized traps and mrets against the model
      for (int i = 0; i < 40; i++) begin
         v.is_mret = 1'($urandom_range(0, 1));
         v.pc      = $urandom;
         v.cause   = 4'($urandom_range(0, 15));
         v.mtvec   = $urandom;
         v.mstatus = $urandom;
         v.mepc    = $urandom;
         v = model(v);
         apply_vec($sformatf("rnd%0d", i), v);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
